// File: rtl/tick_event_logger.sv
// tick_event_logger
//   Timestamps edges of the divided clock (clk1) and trigger strobes (pulse)
//   and queues one record per event cycle in a small FIFO for a consumer.
//
// Ports
//   clk50       in   system clock, all state updates on its rising edge
//   rst         in   synchronous active-high reset
//   clk1        in   slow square wave, synchronous to clk50
//   pulse       in   one-cycle trigger strobe, synchronous to clk50
//   out_ready   in   consumer ready
//   out_valid   out  FIFO holds at least one record
//   out_data    out  head record {rise, fall, pulse, timestamp[TS_W-1:0]}
//   overflow    out  sticky, set when any record is dropped
//   drop_count  out  saturating count of dropped records
module tick_event_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 29
) (
  input  logic            clk50,
  input  logic            rst,
  input  logic            clk1,
  input  logic            pulse,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [TS_W+2:0] out_data,
  output logic            overflow,
  output logic [15:0]     drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_W + 3;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [TS_W-1:0] ts_cnt;
  logic            clk1_q;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  logic rise;
  logic fall;
  logic evt;
  logic pop;
  logic push_ok;
  logic drop;

  assign rise = clk1 & ~clk1_q;
  assign fall = ~clk1 & clk1_q;
  assign evt  = ~rst & (rise | fall | pulse);

  // Gated by rst so the outputs read as empty during the reset cycle itself,
  // before the clearing edge has been taken.
  assign out_valid = ~rst & (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  assign pop = out_valid & out_ready;
  // When full, a same-cycle pop frees the head slot, which is the slot the
  // write pointer already points at.
  assign push_ok = evt & ((count != CNT_FULL) | pop);
  assign drop    = evt & ~push_ok;

  // Edge history is kept through reset so a level already high at release
  // is not mistaken for a rising edge.
  always_ff @(posedge clk50) begin
    clk1_q <= clk1;
  end

  always_ff @(posedge clk50) begin
    if (push_ok) begin
      mem[wr_ptr] <= {rise, fall, pulse, ts_cnt};
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      ts_cnt     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= 16'd0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (!push_ok && pop) begin
        count <= count - (AW+1)'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_event_logger.sv
// tb_tick_event_logger
//   Directed stimulus with a scoreboard: expected records are queued as events
//   are driven, and monitors pop and compare on every accepted transfer.
//   u_dut is the default build (DEPTH=8, TS_W=29); u_wrap is a TS_W=4 build
//   used for the timestamp wrap case.
module tb_tick_event_logger;

  logic        clk50 = 1'b0;
  logic        rst, clk1, pulse, out_ready;
  logic        out_valid, overflow;
  logic [31:0] out_data;
  logic [15:0] drop_count;

  logic        rst_w, clk1_w, pulse_w, ready_w;
  logic        valid_w, overflow_w;
  logic [6:0]  data_w;
  logic [15:0] drop_w;

  int n_chk  = 0;
  int n_pass = 0;
  int tb_ts  = 0;

  logic [31:0] exp_q [$];
  logic [6:0]  exp_w [$];

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;

  always #5 clk50 = ~clk50;

  tick_event_logger #(.DEPTH(8), .TS_W(29)) u_dut (
    .clk50(clk50), .rst(rst), .clk1(clk1), .pulse(pulse), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .overflow(overflow),
    .drop_count(drop_count)
  );

  tick_event_logger #(.DEPTH(4), .TS_W(4)) u_wrap (
    .clk50(clk50), .rst(rst_w), .clk1(clk1_w), .pulse(pulse_w), .out_ready(ready_w),
    .out_valid(valid_w), .out_data(data_w), .overflow(overflow_w),
    .drop_count(drop_w)
  );

  // Cycle counter in timestamp units for the main instance.
  always @(posedge clk50) tb_ts <= rst ? 0 : tb_ts + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic goto_ts(input int n);
    int guard = 0;
    while (tb_ts != n && guard < 200) begin
      step();
      guard++;
    end
    if (tb_ts != n) timeout("goto_ts");
  endtask

  task automatic drain_main();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      step();
      guard++;
    end
    if (exp_q.size() != 0) timeout("drain_main");
  endtask

  function automatic logic [31:0] rec(input logic [2:0] f, input int ts);
    logic [28:0] t;
    t = 29'(ts);
    return {f, t};
  endfunction

  // Scoreboard monitor, main instance: compare on each transfer, and check
  // head stability across a stall.
  always @(negedge clk50) begin
    if (!rst && prev_stall) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", out_data, prev_data);
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) timeout("unexpected_record");
      else chk("record", out_data, exp_q.pop_front());
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_data  = out_data;
  end

  always @(negedge clk50) begin
    if (!rst_w && valid_w && ready_w) begin
      if (exp_w.size() == 0) timeout("unexpected_wrap_record");
      else chk("wrap_record", {25'd0, data_w}, {25'd0, exp_w.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clk1 = 1'b0; pulse = 1'b0; out_ready = 1'b0;
    rst_w = 1'b1; clk1_w = 1'b0; pulse_w = 1'b0; ready_w = 1'b1;

    // Reset; a pulse during reset must be discarded.
    step(); step();
    pulse = 1'b1;
    step();
    pulse = 1'b0;
    @(negedge clk50);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    @(posedge clk50); #1;
    rst = 1'b0;
    chk("rel_valid", {31'd0, out_valid}, 32'd0);
    chk("rel_overflow", {31'd0, overflow}, 32'd0);
    chk("rel_drop", {16'd0, drop_count}, 32'd0);

    // Rise at ts 10, one-cycle latency, empty after pop.
    out_ready = 1'b1;
    goto_ts(10);
    clk1 = 1'b1;
    exp_q.push_back(rec(3'b100, 10));
    step();
    chk("rise_latency", {31'd0, out_valid}, 32'd1);
    step();
    chk("rise_popped", {31'd0, out_valid}, 32'd0);

    // Pulse and fall merge into one record at ts 40.
    goto_ts(40);
    pulse = 1'b1; clk1 = 1'b0;
    exp_q.push_back(rec(3'b011, 40));
    step();
    pulse = 1'b0;
    chk("merge_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("merge_single", {31'd0, out_valid}, 32'd0);

    // Restart and overfill: 10 pulses at ts 5..23 with the consumer stalled.
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      goto_ts(5 + 2 * k);
      pulse = 1'b1;
      if (k < 8) exp_q.push_back(rec(3'b001, 5 + 2 * k));
      step();
      pulse = 1'b0;
    end
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_drops", {16'd0, drop_count}, 32'd2);
    chk("ovf_head", out_data, rec(3'b001, 5));

    // Full FIFO with pop and push in the same cycle: accepted, no drop.
    goto_ts(30);
    out_ready = 1'b1; pulse = 1'b1;
    exp_q.push_back(rec(3'b001, 30));
    step();
    out_ready = 1'b0; pulse = 1'b0;
    chk("full_swap_drops", {16'd0, drop_count}, 32'd2);
    // Still full, so the next stalled pulse is dropped.
    goto_ts(32);
    pulse = 1'b1;
    step();
    pulse = 1'b0;
    chk("still_full_drop", {16'd0, drop_count}, 32'd3);
    out_ready = 1'b1;
    drain_main();
    chk("drained", {31'd0, out_valid}, 32'd0);

    // Queue records, then reset mid-operation with the consumer ready and
    // clk1 high through reset.
    out_ready = 1'b0;
    goto_ts(50); pulse = 1'b1; step(); pulse = 1'b0;
    goto_ts(52); pulse = 1'b1; step(); pulse = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; out_ready = 1'b1; clk1 = 1'b1;
    @(negedge clk50);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    step();
    rst = 1'b0;
    chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    chk("mid_rst_drop", {16'd0, drop_count}, 32'd0);
    chk("mid_rst_flushed", {31'd0, out_valid}, 32'd0);
    goto_ts(4);
    chk("no_false_rise", {31'd0, out_valid}, 32'd0);
    goto_ts(5);
    clk1 = 1'b0;
    exp_q.push_back(rec(3'b010, 5));
    goto_ts(8);
    clk1 = 1'b1;
    exp_q.push_back(rec(3'b100, 8));
    step();
    drain_main();
    chk("main_queue_empty", exp_q.size(), 32'd0);

    // Timestamp wrap on the TS_W=4 build: pulses at ts 15 and 0.
    step();
    rst_w = 1'b0;
    repeat (15) step();
    pulse_w = 1'b1;
    exp_w.push_back({3'b001, 4'd15});
    step();
    exp_w.push_back({3'b001, 4'd0});
    step();
    pulse_w = 1'b0;
    for (int g = 0; g < 10 && exp_w.size() != 0; g++) step();
    if (exp_w.size() != 0) timeout("drain_wrap");
    step();
    chk("wrap_empty", {31'd0, valid_w}, 32'd0);
    chk("wrap_no_drop", {16'd0, drop_w}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tick_event_logger.md
TICK_EVENT_LOGGER -- requirements
Module: tick_event_logger

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the event FIFO depth; legal values are powers of 2, minimum 2.
REQ-002 Parameter TS_W, default 29, SHALL set the timestamp width; the record width is TS_W+3.
REQ-003 clk50  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 clk1  input  1  SHALL be the slow square wave from the clock divider, synchronous to clk50.
REQ-006 pulse  input  1  SHALL be the one-cycle trigger strobe from the clock divider, synchronous to clk50.
REQ-007 out_ready  input  1  SHALL be the consumer ready signal.
REQ-008 out_valid  output  1  SHALL be high while the FIFO holds at least one record.
REQ-009 out_data  output  TS_W+3  SHALL be the head record: [TS_W+2]=rise, [TS_W+1]=fall, [TS_W]=pulse, [TS_W-1:0]=timestamp.
REQ-010 overflow  output  1  SHALL be a sticky flag set when any event is dropped.
REQ-011 drop_count  output  16  SHALL be the saturating count of dropped records.

Function
REQ-012 ts_cnt (TS_W bits) SHALL be 0 in the first cycle after reset, increment by 1 every cycle, and wrap from 2^TS_W-1 to 0.
REQ-013 clk1_q SHALL register clk1 every cycle, including during rst, so no spurious edge occurs at reset release.
REQ-014 Rise SHALL be detected when clk1=1 and clk1_q=0; fall SHALL be detected when clk1=0 and clk1_q=1.
REQ-015 An event cycle SHALL be any cycle with rise, fall, or pulse=1 while rst=0.
REQ-016 Each event cycle SHALL produce exactly one record: flags equal to that cycle's rise/fall/pulse and timestamp equal to that cycle's ts_cnt. Simultaneous events merge into one record.
REQ-017 A record SHALL be written at the clock edge that ends its event cycle. If the FIFO was empty, out_valid SHALL be high in the next cycle (1-cycle latency).
REQ-018 A pop SHALL occur when out_valid=1 and out_ready=1 at the clock edge; the next record SHALL then be presented in the following cycle.
REQ-019 Push acceptance: the push SHALL be accepted if count<DEPTH, or if count=DEPTH and a pop occurs in the same cycle. In both cases count is unchanged on a simultaneous push and pop.
REQ-020 A push not accepted under REQ-019 SHALL be dropped: overflow set to 1, and drop_count incremented, saturating at 16'hFFFF.
REQ-021 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 The FIFO SHALL preserve record order. Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-023 out_valid SHALL NOT depend combinationally on out_ready.

Reset
REQ-024 While rst=1: FIFO emptied, out_valid=0, out_data=0, overflow=0, drop_count=0, and ts_cnt=0.
REQ-025 Events present in a cycle with rst=1 SHALL be discarded.
REQ-026 Reset asserted mid-operation SHALL discard all queued records at the next edge, with no partial pop.

Verification
REQ-027 Reset, then clk1 0->1 at ts_cnt=10 with out_ready=1 -> one cycle later out_valid=1 and out_data={1,0,0,10}; out_valid=0 after the pop.
REQ-028 pulse=1 and clk1 1->0 in the same cycle at ts_cnt=40 -> a single record {0,1,1,40}; no second record.
REQ-029 DEPTH=8, out_ready=0, 10 pulse events at ts 5,7,...,23 -> 8 records held with timestamps 5..19; overflow=1; drop_count=2; draining yields 5,7,...,19 in order.
REQ-030 FIFO full, out_ready=1, and a pulse in the same cycle -> the record is accepted, count stays 8, and drop_count is unchanged.
REQ-031 clk1=1 held during rst, rst released -> no rise record; the first record appears only at the next real edge.
REQ-032 Run 2^TS_W+3 cycles (TS_W=4 build) with a pulse at ts 15 and at ts 0 after wrap -> records carry timestamps 15 then 0 in order.
